hpdcache_rr_grant_arb: RTL and testbench



---
 rtl/hpdcache_pkg.sv | 8 +
 rtl/hpdcache_1hot_to_binary.sv | 16 +
 rtl/hpdcache_rr_grant_arb.sv | 127 ++++++++++++
 tb/tb_hpdcache_rr_grant_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache helpers: wrapped round-robin pointer increment reused by the arbiters.
package hpdcache_pkg;

  function automatic int unsigned hpdcache_rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/hpdcache_1hot_to_binary.sv
// One-hot to binary index decoder; an all-zero input decodes to index 0.
module hpdcache_1hot_to_binary #(
  parameter  int unsigned N     = 4,
  localparam int unsigned Log2N = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     val_i,
  output logic [Log2N-1:0] val_o
);

  always_comb begin
    val_o = '0;
    for (int unsigned i = 0; i < N; i++)
      if (val_i[i]) val_o = val_o | Log2N'(i);
  end

endmodule

// File: rtl/hpdcache_rr_grant_arb.sv
// Round-robin arbiter with ready/valid handshake; a grant stalled by !ready_i is frozen until taken.
// Define HPDCACHE_RR_ARB_STARVE_CHK_EN to add per-requester starvation counters and protocol assertions.
module hpdcache_rr_grant_arb
  import hpdcache_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned Log2N = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             ready_i,
  output logic             gnt_valid_o,
  output logic [N-1:0]     gnt_o,
  output logic [Log2N-1:0] gnt_idx_o
);

  localparam logic UNLOCKED = 1'b0;
  localparam logic LOCKED   = 1'b1;

  logic [Log2N-1:0] ptr_q, ptr_d, ptr_nxt;
  logic             lock_q, lock_d;
  logic [N-1:0]     gnt_q, gnt_d, gnt_rr, sel;
  logic             found;
  int unsigned      k;

  // Scan from ptr_q upward with wrap; first requester found wins.
  always_comb begin
    gnt_rr = '0;
    sel    = '0;
    found  = 1'b0;
    k      = 0;
    for (int unsigned off = 0; off < N; off++) begin
      k = 32'(ptr_q) + off;
      if (k >= N) k = k - N;
      sel = N'(1) << k;
      if (!found && (|(req_i & sel))) begin
        gnt_rr = sel;
        found  = 1'b1;
      end
    end
  end

  hpdcache_1hot_to_binary #(.N(N)) i_gnt_idx (
    .val_i (gnt_o),
    .val_o (gnt_idx_o)
  );

  assign ptr_nxt = Log2N'(hpdcache_rr_next(32'(gnt_idx_o), N));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      lock_q <= UNLOCKED;
      gnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      gnt_q  <= gnt_d;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    lock_d = lock_q;
    gnt_d  = gnt_q;
    case (lock_q)
      UNLOCKED:
        if (gnt_valid_o) begin
          if (ready_i) ptr_d = ptr_nxt;
          else begin
            lock_d = LOCKED;
            gnt_d  = gnt_o;
          end
        end
      LOCKED:
        if (ready_i) begin
          lock_d = UNLOCKED;
          gnt_d  = '0;
          ptr_d  = ptr_nxt;
        end
      default: lock_d = UNLOCKED;
    endcase
  end

  always_comb begin
    gnt_o       = (lock_q == LOCKED) ? gnt_q : gnt_rr;
    gnt_valid_o = |gnt_o;
  end

`ifdef HPDCACHE_RR_ARB_STARVE_CHK_EN
  localparam int unsigned CW = Log2N + 2;

  logic [N-1:0][CW-1:0] wait_q;
  logic [CW-1:0]        rdy_run_q;
  logic                 xfer;

  assign xfer = gnt_valid_o & ready_i;

  // Waits are only judged over a window where ready_i stayed high throughout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q    <= '0;
      rdy_run_q <= '0;
    end else begin
      if (!ready_i)            rdy_run_q <= '0;
      else if (rdy_run_q != '1) rdy_run_q <= rdy_run_q + 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (!req_i[i] || (xfer && gnt_o[i])) wait_q[i] <= '0;
        else if (wait_q[i] != '1)            wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(gnt_o)) else $error("rr_arb: grant not onehot0");
      assert (lock_q != LOCKED || (|(req_i & gnt_q)))
        else $error("rr_arb: locked requester dropped req");
      for (int unsigned i = 0; i < N; i++)
        assert (!(32'(rdy_run_q) > 2 * N && 32'(wait_q[i]) > 2 * N))
          else $error("rr_arb: requester %0d starved", i);
    end
  end
`endif

endmodule

// File: tb/tb_hpdcache_rr_grant_arb.sv
// Directed-vector bench for hpdcache_rr_grant_arb (N=4) with hand-computed grants.
module tb_hpdcache_rr_grant_arb;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] req_i;
  logic       ready_i;
  logic       gnt_valid_o;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;

  int checks = 0;
  int errors = 0;

  hpdcache_rr_grant_arb #(.N(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .ready_i     (ready_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic exp_gnt(input string tag, input logic [3:0] g, input logic [1:0] idx);
    chk({tag, "_vld"}, 32'(gnt_valid_o), 32'(|g));
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, "_idx"}, 32'(gnt_idx_o), 32'(idx));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy);
    req_i   = r;
    ready_i = rdy;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(4'b0000, 1'b0);
    exp_gnt("rst_idle", 4'b0000, 2'd0);
    drive(4'b0100, 1'b0);
    exp_gnt("rst_comb", 4'b0100, 2'd2);
    repeat (2) tick();
    exp_gnt("rst_nolock", 4'b0100, 2'd2);
    drive(4'b0100, 1'b1);
    exp_gnt("rst_ready", 4'b0100, 2'd2);

    rst_ni = 1'b1;
    drive(4'b0000, 1'b1);
    exp_gnt("idle", 4'b0000, 2'd0);
    tick();
    exp_gnt("idle_rdy", 4'b0000, 2'd0);

    drive(4'b1010, 1'b1);
    exp_gnt("first", 4'b0010, 2'd1);
    tick();
    exp_gnt("second", 4'b1000, 2'd3);
    tick();

    drive(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_gnt($sformatf("rr%0d", i), 4'b0001 << (i % 4), 2'(i % 4));
      tick();
    end

    drive(4'b0001, 1'b1);
    exp_gnt("to_ptr1", 4'b0001, 2'd0);
    tick();
    drive(4'b0100, 1'b0);
    exp_gnt("stall0", 4'b0100, 2'd2);
    tick();
    drive(4'b0101, 1'b0);
    exp_gnt("stall1", 4'b0100, 2'd2);
    tick();
    drive(4'b1111, 1'b0);
    exp_gnt("stall2", 4'b0100, 2'd2);
    tick();
    drive(4'b0001, 1'b0);
    exp_gnt("noretract", 4'b0100, 2'd2);
    tick();
    drive(4'b0101, 1'b1);
    exp_gnt("accept", 4'b0100, 2'd2);
    tick();
    exp_gnt("after_stall", 4'b0001, 2'd0);
    tick();

    drive(4'b0100, 1'b1);
    exp_gnt("to_ptr3", 4'b0100, 2'd2);
    tick();
    drive(4'b1001, 1'b1);
    exp_gnt("wrap3", 4'b1000, 2'd3);
    tick();
    exp_gnt("wrap0", 4'b0001, 2'd0);
    tick();
    exp_gnt("wrap_ptr1", 4'b1000, 2'd3);
    tick();

    drive(4'b0100, 1'b0);
    exp_gnt("lock_set", 4'b0100, 2'd2);
    tick();
    drive(4'b0001, 1'b0);
    exp_gnt("lock_pre", 4'b0100, 2'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    exp_gnt("rst_async", 4'b0001, 2'd0);
    req_i = 4'b0100;
    #1;
    exp_gnt("rst_unlk", 4'b0100, 2'd2);
    tick();
    rst_ni = 1'b1;
    drive(4'b1000, 1'b0);
    exp_gnt("post_rst", 4'b1000, 2'd3);
    tick();
    drive(4'b0001, 1'b0);
    exp_gnt("post_rst_lock", 4'b1000, 2'd3);
    drive(4'b1001, 1'b1);
    tick();
    drive(4'b0011, 1'b1);
    exp_gnt("final", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
